// File: rtl/mem_burst_reader_pkg.sv
// Shared types and default widths for the burst reader and its counter.
// No logic; latency and backpressure are not applicable.
package mem_pkg;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PRESENT,
    DONE
  } state_t;
endpackage

// File: rtl/mem_burst_reader_if.sv
// Control, memory-slave and stream signals of the burst reader as one bundle.
// The master modport is the reader's view; the slave modport is the environment's view.
interface mem_burst_reader_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
);
  logic                     iStart;
  logic [ADDRESS_WIDTH-1:0] iBaseAddr;
  logic [ADDRESS_WIDTH:0]   iLength;
  logic                     oBusy;
  logic                     oDone;
  logic                     oChipSelect_n;
  logic                     oRead_n;
  logic                     oWrite_n;
  logic [ADDRESS_WIDTH-1:0] oAddress;
  logic [DATA_WIDTH-1:0]    iMemData;
  logic [DATA_WIDTH-1:0]    oStreamData;
  logic                     oStreamValid;
  logic                     iStreamReady;

  modport master (
    input  iStart, iBaseAddr, iLength, iMemData, iStreamReady,
    output oBusy, oDone, oChipSelect_n, oRead_n, oWrite_n, oAddress,
           oStreamData, oStreamValid
  );

  modport slave (
    output iStart, iBaseAddr, iLength, iMemData, iStreamReady,
    input  oBusy, oDone, oChipSelect_n, oRead_n, oWrite_n, oAddress,
           oStreamData, oStreamValid
  );
endinterface

// File: rtl/mem_burst_reader_addr_counter.sv
// Word address / words-remaining pair: load on start, step once per word, address wraps.
// Single-cycle update; no backpressure of its own (stepping is gated by the caller).
module mem_addr_counter
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic [ADDRESS_WIDTH-1:0] i_base,
  input  logic [ADDRESS_WIDTH:0]   i_len,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic                     o_zero
);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   REM_ONE  = 1;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;

  // Address addition is naturally modulo the memory depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_base;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_addr      <= r_addr + ADDR_ONE;
      r_remaining <= r_remaining - REM_ONE;
    end
  end

  assign o_addr = r_addr;
  assign o_zero = (r_remaining == '0);
endmodule

// File: rtl/mem_burst_reader.sv
// Avalon-style burst read master: FETCH/LOAD/PRESENT per word, 3 cycles per word, first valid 3 cycles after start.
// PRESENT holds word and valid until iStreamReady; no new read is issued while stalled.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic         iClk,
  input  logic         iReset_n,
  mem_burst_reader_if.master bus
);
  state_t                   r_state;
  state_t                   w_next;
  logic                     w_load;
  logic                     w_step;
  logic                     w_zero;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    r_stream_dat;

  mem_addr_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_addr_counter (
    .i_clk   (iClk),
    .i_rst_n (iReset_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_base  (bus.iBaseAddr),
    .i_len   (bus.iLength),
    .o_addr  (w_addr),
    .o_zero  (w_zero)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.iStart) begin
          if (bus.iLength != '0) begin
            w_next = FETCH;
            w_load = 1'b1;
          end else begin
            w_next = DONE;
          end
        end
      end
      FETCH:   w_next = LOAD;
      LOAD: begin
        w_step = 1'b1;
        w_next = PRESENT;
      end
      // Remaining was already decremented in LOAD, so zero here means last word.
      PRESENT: begin
        if (bus.iStreamReady) begin
          w_next = w_zero ? DONE : FETCH;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slave read data is valid during LOAD, one cycle after the address was latched.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_stream_dat <= '0;
    end else if (r_state == LOAD) begin
      r_stream_dat <= bus.iMemData;
    end
  end

  assign bus.oBusy         = (r_state == FETCH) || (r_state == LOAD) || (r_state == PRESENT);
  assign bus.oDone         = (r_state == DONE);
  assign bus.oChipSelect_n = (r_state != FETCH);
  assign bus.oRead_n       = (r_state != FETCH);
  assign bus.oWrite_n      = 1'b1;
  assign bus.oAddress      = w_addr;
  assign bus.oStreamData   = r_stream_dat;
  assign bus.oStreamValid  = (r_state == PRESENT);
endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a registered-address memory slave model and a per-cycle checker.
// The expected address/word sequence of each burst is derived from base, length and the preload rule.
module tb_mem_burst_reader;
  import mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_burst_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_burst_reader #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus.master)
  );

  // Memory slave: address registered on a strobed edge, data presented the next cycle.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] lat_addr = '0;
  initial for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA0 + k;
  always @(posedge clk) if (!bus.oChipSelect_n && !bus.oRead_n) lat_addr <= bus.oAddress;
  assign bus.iMemData = mem[lat_addr];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s", name);
  endtask

  // Model state and observations of the current burst.
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_dat_q  [$];
  logic [AW-1:0] obs_addr   [$];
  logic [DW-1:0] obs_dat    [$];
  int            valid_rel  [$];
  int  cyc = 0;
  int  start_cyc = 0;
  int  done_rel = -1;
  bit  done_seen = 0;
  int  strobe_cnt = 0;
  int  busy_cnt = 0;
  bit  stall_prev = 0;
  logic [DW-1:0] stall_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("write_n_high", bus.oWrite_n, 1);
      if (!bus.oChipSelect_n) begin
        strobe_cnt++;
        obs_addr.push_back(bus.oAddress);
        check("read_n_with_cs", bus.oRead_n, 0);
        if (exp_addr_q.size() == 0) fail_now("unexpected_strobe");
        else check("strobe_addr", bus.oAddress, exp_addr_q.pop_front());
      end
      if (bus.oBusy) busy_cnt++;
      if (bus.oDone) begin
        done_seen = 1;
        done_rel  = cyc - start_cyc;
        check("busy_low_in_done", bus.oBusy, 0);
      end
      if (bus.oStreamValid) begin
        if (stall_prev) check("stall_data_stable", bus.oStreamData, stall_dat);
        if (bus.iStreamReady) begin
          valid_rel.push_back(cyc - start_cyc);
          obs_dat.push_back(bus.oStreamData);
          if (exp_dat_q.size() == 0) fail_now("unexpected_word");
          else check("stream_word", bus.oStreamData, exp_dat_q.pop_front());
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_dat  = bus.oStreamData;
        end
      end else begin
        stall_prev = 0;
      end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW:0] len);
    @(posedge clk);
    #1;
    bus.iStart    = 1'b1;
    bus.iBaseAddr = base;
    bus.iLength   = len;
    start_cyc  = cyc;
    done_seen  = 0;
    done_rel   = -1;
    strobe_cnt = 0;
    busy_cnt   = 0;
    obs_addr.delete();
    obs_dat.delete();
    valid_rel.delete();
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = AW'(int'(base) + i);
      exp_addr_q.push_back(a);
      exp_dat_q.push_back(32'hA0 + 32'(a));
    end
    tick(1);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done_seen && n < bound) begin
      tick(1);
      n++;
    end
    if (!done_seen) fail_now("done_timeout");
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!bus.oStreamValid && n < bound) begin
      tick(1);
      n++;
    end
    if (!bus.oStreamValid) fail_now("valid_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  bus.oBusy, 0);
    check({tag, "_done"},  bus.oDone, 0);
    check({tag, "_cs_n"},  bus.oChipSelect_n, 1);
    check({tag, "_rd_n"},  bus.oRead_n, 1);
    check({tag, "_wr_n"},  bus.oWrite_n, 1);
    check({tag, "_addr"},  bus.oAddress, 0);
    check({tag, "_data"},  bus.oStreamData, 0);
    check({tag, "_valid"}, bus.oStreamValid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    bit seen [DEPTH];
    int distinct;
    bus.iStart       = 1'b0;
    bus.iBaseAddr    = '0;
    bus.iLength      = '0;
    bus.iStreamReady = 1'b1;
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic burst: words on cycles 3, 6, 9, done on 10.
    start(4'd2, 5'd3);
    wait_done(40);
    check("t1_nwords", valid_rel.size(), 3);
    check("t1_valid0_cycle", valid_rel[0], 3);
    check("t1_valid1_cycle", valid_rel[1], 6);
    check("t1_valid2_cycle", valid_rel[2], 9);
    check("t1_done_cycle", done_rel, 10);
    check("t1_strobes", strobe_cnt, 3);
    check("t1_busy_cycles", busy_cnt, 9);
    check("t1_word0", obs_dat[0], 32'hA2);
    check("t1_word1", obs_dat[1], 32'hA3);
    check("t1_word2", obs_dat[2], 32'hA4);

    // Wrap across the top address.
    start(4'd14, 5'd4);
    wait_done(40);
    check("t2_addr0", obs_addr[0], 14);
    check("t2_addr1", obs_addr[1], 15);
    check("t2_addr2", obs_addr[2], 0);
    check("t2_addr3", obs_addr[3], 1);
    check("t2_word0", obs_dat[0], 32'hAE);
    check("t2_word1", obs_dat[1], 32'hAF);
    check("t2_word2", obs_dat[2], 32'hA0);
    check("t2_word3", obs_dat[3], 32'hA1);
    check("t2_done_cycle", done_rel, 13);

    // Backpressure: five stalled cycles on the first word.
    bus.iStreamReady = 1'b0;
    start(4'd2, 5'd2);
    wait_valid(20);
    s = strobe_cnt;
    tick(5);
    check("t3_valid_held", bus.oStreamValid, 1);
    check("t3_data_held", bus.oStreamData, 32'hA2);
    check("t3_no_strobe_in_stall", strobe_cnt, s);
    check("t3_strobes_before_release", strobe_cnt, 1);
    bus.iStreamReady = 1'b1;
    wait_done(40);
    check("t3_nwords", obs_dat.size(), 2);
    check("t3_word0", obs_dat[0], 32'hA2);
    check("t3_word1", obs_dat[1], 32'hA3);
    check("t3_done_cycle", done_rel, 12);

    // Zero length: straight to DONE, no strobes, never busy.
    start(4'd7, 5'd0);
    wait_done(10);
    tick(3);
    check("t4_done_cycle", done_rel, 1);
    check("t4_strobes", strobe_cnt, 0);
    check("t4_busy_cycles", busy_cnt, 0);

    // Start pulsed mid-burst must be ignored.
    start(4'd0, 5'd3);
    tick(3);
    bus.iStart    = 1'b1;
    bus.iBaseAddr = 4'd9;
    bus.iLength   = 5'd5;
    tick(1);
    bus.iStart = 1'b0;
    wait_done(40);
    tick(6);
    check("t5_nwords", obs_dat.size(), 3);
    check("t5_strobes", strobe_cnt, 3);
    check("t5_done_cycle", done_rel, 10);
    check("t5_model_drained", exp_addr_q.size(), 0);

    // Reset while PRESENT: outputs drop in the same cycle, no done afterwards.
    bus.iStreamReady = 1'b0;
    start(4'd0, 5'd3);
    wait_valid(20);
    tick(1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_addr_q.delete();
    exp_dat_q.delete();
    tick(2);
    rst_n = 1'b1;
    bus.iStreamReady = 1'b1;
    s = strobe_cnt;
    tick(4);
    check("t6_no_done_after_abort", done_seen, 0);
    check("t6_idle_after_abort", strobe_cnt, s);

    // Full-depth burst from base 5 after the abort.
    start(4'd5, 5'd16);
    wait_done(100);
    check("t7_nwords", obs_dat.size(), 16);
    check("t7_done_cycle", done_rel, 49);
    check("t7_word0", obs_dat[0], 32'hA5);
    check("t7_word10", obs_dat[10], 32'hAF);
    check("t7_word11", obs_dat[11], 32'hA0);
    check("t7_word15", obs_dat[15], 32'hA4);
    distinct = 0;
    for (int i = 0; i < DEPTH; i++) seen[i] = 0;
    for (int i = 0; i < obs_addr.size(); i++) begin
      if (!seen[obs_addr[i]]) distinct++;
      seen[obs_addr[i]] = 1;
    end
    check("t7_distinct_addrs", distinct, 16);
    check("t7_strobes", strobe_cnt, 16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Avalon-style read master that sits directly upstream of the register-file Memory slave.
- On a start pulse it reads `iLength` consecutive words beginning at `iBaseAddr`.
- Each word is presented on a valid/ready stream with full backpressure support.
- It drives the slave's active-low chip-select, read and write strobes, and consumes the slave's one-cycle registered-address read data.

Parameters:
- DATA_WIDTH, 32, word width; must match the Memory slave.
- ADDRESS_WIDTH, 4, slave address width; memory depth is 2**ADDRESS_WIDTH.

Ports:
- iClk  in  1  system clock; all logic on the rising edge.
- iReset_n  in  1  asynchronous, active-low reset; one clock domain only.
- iStart  in  1  start request; sampled only in IDLE.
- iBaseAddr  in  ADDRESS_WIDTH  first word address.
- iLength  in  ADDRESS_WIDTH+1  word count, 0..2**ADDRESS_WIDTH.
- oBusy  out  1  high from the cycle after an accepted start until oDone.
- oDone  out  1  one-cycle completion pulse.
- oChipSelect_n  out  1  slave chip select, active low.
- oRead_n  out  1  slave read strobe, active low.
- oWrite_n  out  1  slave write strobe; constant 1.
- oAddress  out  ADDRESS_WIDTH  slave address.
- iMemData  in  DATA_WIDTH  slave read data; valid the cycle after a read-strobe edge.
- oStreamData  out  DATA_WIDTH  stream word.
- oStreamValid  out  1  stream valid.
- iStreamReady  in  1  stream ready from the consumer.

Behaviour:
- Reset values, asynchronous on `iReset_n`=0:
  - state=IDLE, oBusy=0, oDone=0.
  - oChipSelect_n=1, oRead_n=1, oWrite_n=1.
  - oAddress=0, oStreamData=0, oStreamValid=0.
  - Internal address and remaining counters = 0.
- Reset mid-burst aborts immediately; no partial-completion pulse is generated.
- All outputs are decoded from registered state/datapath only. There is no combinational path from iStreamReady or iStart to any output.
- State machine, one cycle per state unless noted:
  - IDLE:
    - iStart=1 and iLength≠0 → FETCH; load addr=iBaseAddr, remaining=iLength.
    - iStart=1 and iLength=0 → DONE.
    - iStart=0 → stay in IDLE.
  - FETCH:
    - oChipSelect_n=0, oRead_n=0, oAddress=addr.
    - The slave latches the address at the closing edge.
    - → LOAD.
  - LOAD:
    - Strobes high; oAddress holds.
    - Capture iMemData into oStreamData at the closing edge.
    - addr←addr+1, wrapping mod 2**ADDRESS_WIDTH.
    - remaining←remaining−1.
    - → PRESENT.
  - PRESENT:
    - oStreamValid=1; oStreamData held stable.
    - On iStreamReady=1: remaining≠0 → FETCH; remaining=0 → DONE.
    - Otherwise hold for any number of cycles.
  - DONE:
    - oDone=1, oBusy=0.
    - → IDLE.
- oBusy=1 in FETCH, LOAD and PRESENT.
- iStart while busy is ignored; there is no queuing.
- Throughput: 3 cycles per word with iStreamReady held high.
- Latency: start edge → first oStreamValid = 3 cycles (FETCH, LOAD, PRESENT).
- Last handshake → oDone in the next cycle. From DONE, a new iStart is accepted in the following IDLE cycle.
- Address wrap: a burst crossing the top address continues at address 0.
- Length 2**ADDRESS_WIDTH reads every word exactly once.
- oWrite_n is never asserted, so the slave contents are unaffected.

Decomposition:
- Shared package mem_pkg:
  - state enum typedef {IDLE, FETCH, LOAD, PRESENT, DONE}.
  - Default width constants DATA_WIDTH_DEF=32, ADDRESS_WIDTH_DEF=4.
- The address/remaining counter pair is a natural sub-module, mem_addr_counter. It provides load, step, wrap and zero-flag.
- The FSM and output registers stay in the top module.

Test Plan:
- Memory preloaded with mem[k]=32'hA0+k. Start base=2, len=3, ready=1 → stream 0xA2, 0xA3, 0xA4 on cycles 3, 6, 9 after start; oDone pulse at cycle 10; exactly 3 chip-select/read strobe cycles.
- Base=14, len=4 → addresses 14, 15, 0, 1; data 0xAE, 0xAF, 0xA0, 0xA1.
- Backpressure: len=2, ready held low 5 cycles while valid → oStreamData stable at 0xA2 and no new read strobe during the stall; proceeds after ready rises.
- len=0 → no strobes; oDone one cycle after start; oBusy stays 0.
- iStart pulsed during a burst → ignored; word count unchanged. Reset asserted during PRESENT → all outputs return to reset values the same cycle. A fresh start after reset works normally.
- len=16, base=5 → all 16 words streamed in order, each exactly once; oWrite_n stays 1 throughout.
